// File: rtl/lsu_ctrl.sv
// Load/store unit controller: one outstanding request, byte-lane steering, load extension, access timeout.
// Optional alignment trap is enabled by defining the macro LSU_MISALIGN_TRAP_EN.
module lsu_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 32'd1);

    state_t      state_q;
    logic [15:0] tmo_cnt_q;
    logic        we_q;
    logic        uns_q;
    logic [1:0]  size_q;
    logic [1:0]  off_q;

    logic        req_ready_q;
    logic        resp_valid_q;
    logic        resp_err_q;
    logic [31:0] resp_rdata_q;
    logic        mem_req_q;
    logic        mem_we_q;
    logic [31:0] mem_addr_q;
    logic [3:0]  mem_be_q;
    logic [31:0] mem_wdata_q;

    logic        misalign_s;
    logic        pre_err_s;

    function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b00:   lane_be = 4'b0001 << off;
            2'b01:   lane_be = off[1] ? 4'b1100 : 4'b0011;
            2'b10:   lane_be = 4'b1111;
            default: lane_be = 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] wdata_rep(input logic [1:0] size, input logic [31:0] w);
        case (size)
            2'b00:   wdata_rep = {4{w[7:0]}};
            2'b01:   wdata_rep = {2{w[15:0]}};
            default: wdata_rep = w;
        endcase
    endfunction

    function automatic logic [31:0] load_ext(input logic [1:0] size, input logic uns,
                                             input logic [1:0] off, input logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'b00:   b = d[7:0];
            2'b01:   b = d[15:8];
            2'b10:   b = d[23:16];
            default: b = d[31:24];
        endcase
        h = off[1] ? d[31:16] : d[15:0];
        case (size)
            2'b00:   load_ext = uns ? {24'h000000, b} : {{24{b[7]}}, b};
            2'b01:   load_ext = uns ? {16'h0000, h} : {{16{h[15]}}, h};
            2'b10:   load_ext = d;
            default: load_ext = 32'h0000_0000;
        endcase
    endfunction

`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign_s = ((req_size == 2'b01) && req_addr[0]) ||
                        ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
`else
    assign misalign_s = 1'b0;
`endif

    assign pre_err_s = (req_size == 2'b11) || misalign_s;

    // Request FSM with all outputs registered; errors detected at acceptance bypass the memory access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            tmo_cnt_q    <= 16'd0;
            we_q         <= 1'b0;
            uns_q        <= 1'b0;
            size_q       <= 2'b00;
            off_q        <= 2'b00;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'h0000_0000;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 32'h0000_0000;
            mem_be_q     <= 4'b0000;
            mem_wdata_q  <= 32'h0000_0000;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        we_q        <= req_we;
                        uns_q       <= req_unsigned;
                        size_q      <= req_size;
                        off_q       <= req_addr[1:0];
                        tmo_cnt_q   <= 16'd0;
                        req_ready_q <= 1'b0;
                        if (pre_err_s) begin
                            state_q      <= S_RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_rdata_q <= 32'h0000_0000;
                        end else begin
                            state_q     <= S_ACCESS;
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= req_we;
                            mem_addr_q  <= {req_addr[31:2], 2'b00};
                            mem_be_q    <= lane_be(req_size, req_addr[1:0]);
                            mem_wdata_q <= wdata_rep(req_size, req_wdata);
                        end
                    end else begin
                        req_ready_q <= 1'b1;
                    end
                end
                S_ACCESS: begin
                    // An acknowledge on the expiry cycle still completes normally.
                    if (mem_ack) begin
                        state_q      <= S_RESP;
                        mem_req_q    <= 1'b0;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b0;
                        resp_rdata_q <= we_q ? 32'h0000_0000 : load_ext(size_q, uns_q, off_q, mem_rdata);
                    end else if (tmo_cnt_q == TMO_LAST) begin
                        state_q      <= S_RESP;
                        mem_req_q    <= 1'b0;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b1;
                        resp_rdata_q <= 32'h0000_0000;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 16'd1;
                    end
                end
                S_RESP: begin
                    state_q      <= S_IDLE;
                    req_ready_q  <= 1'b1;
                    resp_valid_q <= 1'b0;
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= 32'h0000_0000;
                end
                default: begin
                    state_q      <= S_IDLE;
                    req_ready_q  <= 1'b1;
                    resp_valid_q <= 1'b0;
                    resp_err_q   <= 1'b0;
                    mem_req_q    <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_be     = mem_be_q;
    assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed vectors plus randomized transactions against a lane/extension model.
module tb_lsu_ctrl;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'h0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lsu_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    // Reference: access width in bytes, lane offset, mask-and-shift extraction.
    function automatic void model(input logic we, input logic [1:0] size, input logic uns,
                                  input logic [31:0] addr, input logic [31:0] wdata, input int delay,
                                  input logic [31:0] mrd, output logic e_err, output logic [31:0] e_rd,
                                  output int e_acc, output int e_lat, output logic [3:0] e_be,
                                  output logic [31:0] e_wd);
        int bytes;
        int lane;
        logic [31:0] mask;
        logic [31:0] v;
        bit pre_err;
        bytes = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
        mask = (bytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * bytes)) - 32'd1);
        pre_err = (size == 2'b11);
`ifdef LSU_MISALIGN_TRAP_EN
        if (size != 2'b11 && (int'(addr[1:0]) % bytes) != 0) pre_err = 1'b1;
`endif
        lane = int'(addr[1:0]) & ~(bytes - 1);
        e_be = 4'(((1 << bytes) - 1) << lane);
        e_wd = (wdata & mask) * ((bytes == 1) ? 32'h0101_0101 : (bytes == 2) ? 32'h0001_0001 : 32'h1);
        if (pre_err) begin
            e_err = 1'b1; e_rd = 32'h0; e_acc = 0; e_lat = 1;
        end else if (delay >= TMO) begin
            e_err = 1'b1; e_rd = 32'h0; e_acc = TMO; e_lat = TMO + 1;
        end else begin
            e_err = 1'b0; e_acc = delay + 1; e_lat = delay + 2;
            v = (mrd >> (8 * lane)) & mask;
            if (!uns && bytes < 4 && v[8 * bytes - 1]) v = v | ~mask;
            e_rd = we ? 32'h0 : v;
        end
    endfunction

    task automatic run_txn(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata, input int delay,
                           input logic [31:0] mrd, output logic rdy0, output int acc,
                           output logic [3:0] be, output logic [31:0] maddr, output logic [31:0] mwd,
                           output logic mwe, output logic [31:0] rd, output logic err,
                           output int lat, output logic hold);
        @(negedge clk);
        rdy0 = req_ready;
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        @(posedge clk);
        #1 req_valid = 1'b0;
        acc = 0; lat = 0; be = 4'h0; maddr = 32'h0; mwd = 32'h0; mwe = 1'b0;
        rd = 32'h0; err = 1'b0; hold = 1'b0;
        for (int k = 1; k <= TMO + 6; k++) begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (mem_req) begin
                acc++;
                be = mem_be; maddr = mem_addr; mwd = mem_wdata; mwe = mem_we;
                if (acc - 1 == delay) begin
                    mem_ack = 1'b1; mem_rdata = mrd;
                end else begin
                    mem_rdata = $urandom;
                end
            end
            if (resp_valid) begin
                rd = resp_rdata; err = resp_err; lat = k;
                break;
            end
        end
        mem_ack = 1'b0;
        @(negedge clk);
        hold = resp_valid;
    endtask

    task automatic test_reset();
        logic [104:0] obs;
        rst = 1'b1;
        @(negedge clk);
        obs = {req_ready, resp_valid, resp_err, resp_rdata, mem_req, mem_we, mem_addr, mem_be, mem_wdata};
        checks++;
        if (obs !== {1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0}) begin
            errors++; $display("FAIL reset_during: got %h expected ready=1 others 0", obs);
        end
        rst = 1'b0;
        @(negedge clk);
        obs = {req_ready, resp_valid, resp_err, resp_rdata, mem_req, mem_we, mem_addr, mem_be, mem_wdata};
        checks++;
        if (obs !== {1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0}) begin
            errors++; $display("FAIL reset_after: got %h expected ready=1 others 0", obs);
        end
    endtask

    task automatic test_directed();
        logic rdy0, mwe, err, hold;
        int acc, lat;
        logic [3:0] be;
        logic [31:0] maddr, mwd, rd;
        run_txn(1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 0, 32'h80FF_1234, rdy0, acc, be, maddr, mwd, mwe, rd, err, lat, hold);
        checks++;
        if ({maddr, be, rd, err} !== {32'h100, 4'b1000, 32'hFFFF_FF80, 1'b0} || lat !== 2) begin
            errors++; $display("FAIL lb_signed: addr=%h be=%b rd=%h err=%b lat=%0d expected 100 1000 ffffff80 0 2", maddr, be, rd, err, lat);
        end
        run_txn(1'b0, 2'b01, 1'b1, 32'h102, 32'h0, 0, 32'h9ABC_0000, rdy0, acc, be, maddr, mwd, mwe, rd, err, lat, hold);
        checks++;
        if ({be, rd, err} !== {4'b1100, 32'h0000_9ABC, 1'b0}) begin
            errors++; $display("FAIL lhu: be=%b rd=%h err=%b expected 1100 00009abc 0", be, rd, err);
        end
        run_txn(1'b1, 2'b00, 1'b0, 32'h201, 32'h0000_00A5, 0, 32'h1234_5678, rdy0, acc, be, maddr, mwd, mwe, rd, err, lat, hold);
        checks++;
        if ({mwe, be, mwd, rd, err} !== {1'b1, 4'b0010, 32'hA5A5_A5A5, 32'h0, 1'b0}) begin
            errors++; $display("FAIL sb: we=%b be=%b wd=%h rd=%h err=%b expected 1 0010 a5a5a5a5 0 0", mwe, be, mwd, rd, err);
        end
        run_txn(1'b0, 2'b10, 1'b0, 32'h300, 32'h0, 99, 32'h0, rdy0, acc, be, maddr, mwd, mwe, rd, err, lat, hold);
        checks++;
        if (acc !== TMO || err !== 1'b1 || rd !== 32'h0 || lat !== TMO + 1) begin
            errors++; $display("FAIL timeout: acc=%0d err=%b rd=%h lat=%0d expected %0d 1 0 %0d", acc, err, rd, lat, TMO, TMO + 1);
        end
        run_txn(1'b0, 2'b10, 1'b0, 32'h300, 32'h0, TMO - 1, 32'hCAFE_F00D, rdy0, acc, be, maddr, mwd, mwe, rd, err, lat, hold);
        checks++;
        if (acc !== TMO || err !== 1'b0 || rd !== 32'hCAFE_F00D) begin
            errors++; $display("FAIL ack_at_expiry: acc=%0d err=%b rd=%h expected %0d 0 cafef00d", acc, err, rd, TMO);
        end
        run_txn(1'b0, 2'b11, 1'b0, 32'h400, 32'h0, 0, 32'h0, rdy0, acc, be, maddr, mwd, mwe, rd, err, lat, hold);
        checks++;
        if (acc !== 0 || err !== 1'b1 || lat !== 1 || hold !== 1'b0) begin
            errors++; $display("FAIL illegal_size: acc=%0d err=%b lat=%0d hold=%b expected 0 1 1 0", acc, err, lat, hold);
        end
        run_txn(1'b0, 2'b10, 1'b0, 32'h102, 32'h0, 0, 32'h1111_2222, rdy0, acc, be, maddr, mwd, mwe, rd, err, lat, hold);
        checks++;
`ifdef LSU_MISALIGN_TRAP_EN
        if (acc !== 0 || err !== 1'b1) begin
            errors++; $display("FAIL misalign_word: acc=%0d err=%b expected 0 1", acc, err);
        end
`else
        if ({maddr, be, err} !== {32'h100, 4'b1111, 1'b0}) begin
            errors++; $display("FAIL misalign_word: addr=%h be=%b err=%b expected 100 1111 0", maddr, be, err);
        end
`endif
    endtask

    task automatic test_ack_outside();
        bit bad = 1'b0;
        mem_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (mem_req || resp_valid || !req_ready) bad = 1'b1;
        end
        mem_ack = 1'b0;
        checks++;
        if (bad) begin
            errors++; $display("FAIL ack_idle: activity=1 expected 0");
        end
    endtask

    task automatic test_reset_mid_access();
        bit seen = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 32'h500;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b1) begin
            errors++; $display("FAIL rst_mid_pre: mem_req=%b expected 1", mem_req);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (mem_req !== 1'b0) begin
            errors++; $display("FAIL rst_mid_drop: mem_req=%b expected 0", mem_req);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < TMO + 3; i++) begin
            @(negedge clk);
            if (resp_valid) seen = 1'b1;
        end
        checks++;
        if (seen || req_ready !== 1'b1) begin
            errors++; $display("FAIL rst_mid_after: resp_seen=%b ready=%b expected 0 1", seen, req_ready);
        end
    endtask

    task automatic test_random();
        logic rdy0, mwe, err, hold, we, uns, e_err;
        int acc, lat, delay, e_acc, e_lat;
        logic [1:0] size;
        logic [3:0] be, e_be;
        logic [31:0] maddr, mwd, rd, addr, wdata, mrd, e_rd, e_wd;
        for (int n = 0; n < 80; n++) begin
            we = 1'($urandom_range(0, 1));
            size = 2'($urandom_range(0, 3));
            uns = 1'($urandom_range(0, 1));
            addr = $urandom; wdata = $urandom; mrd = $urandom;
            delay = $urandom_range(0, TMO + 1);
            model(we, size, uns, addr, wdata, delay, mrd, e_err, e_rd, e_acc, e_lat, e_be, e_wd);
            run_txn(we, size, uns, addr, wdata, delay, mrd, rdy0, acc, be, maddr, mwd, mwe, rd, err, lat, hold);
            checks++;
            if (rdy0 !== 1'b1 || hold !== 1'b0) begin
                errors++; $display("FAIL rnd_handshake[%0d]: ready=%b hold=%b expected 1 0", n, rdy0, hold);
            end
            checks++;
            if (err !== e_err || rd !== e_rd || lat !== e_lat || acc !== e_acc) begin
                errors++; $display("FAIL rnd_resp[%0d]: err=%b rd=%h lat=%0d acc=%0d expected %b %h %0d %0d",
                                   n, err, rd, lat, acc, e_err, e_rd, e_lat, e_acc);
            end
            if (acc > 0) begin
                checks++;
                if (be !== e_be || maddr !== (addr & ~32'h3) || mwd !== e_wd || mwe !== we) begin
                    errors++; $display("FAIL rnd_mem[%0d]: be=%b addr=%h wd=%h we=%b expected %b %h %h %b",
                                       n, be, maddr, mwd, mwe, e_be, addr & ~32'h3, e_wd, we);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ack_outside();
        test_reset_mid_access();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: maximum ACCESS-state cycles to wait for mem_ack (1..65535).
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have port req_valid  in  1  pipeline load/store request.
REQ-005 SHALL have port req_ready  out  1  request accepted when req_valid and req_ready are both high on an edge.
REQ-006 SHALL have port req_we  in  1  1 = store, 0 = load.
REQ-007 SHALL have port req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-008 SHALL have port req_unsigned  in  1  zero-extend loads (LBU/LHU) when 1, sign-extend when 0.
REQ-009 SHALL have port req_addr  in  32  byte address.
REQ-010 SHALL have port req_wdata  in  32  store data, right-aligned.
REQ-011 SHALL have port resp_valid  out  1  one-cycle completion pulse.
REQ-012 SHALL have port resp_rdata  out  32  extended load data; 0 for stores and errors.
REQ-013 SHALL have port resp_err  out  1  qualified by resp_valid: misaligned, illegal size or timeout.
REQ-014 SHALL have port mem_req  out  1  memory access strobe, held until mem_ack.
REQ-015 SHALL have ports mem_we (out 1), mem_addr (out 32, word-aligned, bits[1:0]=0), mem_be (out 4), mem_wdata (out 32).
REQ-016 SHALL have ports mem_ack (in 1, access done) and mem_rdata (in 32, valid when mem_ack).

Function
REQ-017 SHALL implement FSM IDLE, ACCESS, RESP; req_ready = 1 only in IDLE.
REQ-018 In IDLE, on acceptance, SHALL register we, size, unsigned, addr, wdata and go to ACCESS, or to RESP with error flagged if size = 11 (or misaligned per REQ-031).
REQ-019 In ACCESS, SHALL drive mem_req = 1 with stable mem_we/mem_addr/mem_be/mem_wdata from the registered request.
REQ-020 On mem_ack in ACCESS, SHALL capture extracted load data and go to RESP next edge; mem_req drops in RESP.
REQ-021 SHALL count ACCESS cycles; if TIMEOUT_CYCLES cycles elapse without mem_ack, go to RESP with resp_err = 1 and resp_rdata = 0; mem_ack in the same cycle as expiry wins (no error).
REQ-022 In RESP, SHALL assert resp_valid for exactly one cycle, then return to IDLE; best-case latency acceptance-to-resp_valid is 2 cycles with same-cycle mem_ack.
REQ-023 Byte lanes: mem_be = 0001<<addr[1:0] (byte), 0011<<{addr[1],0} (half), 1111 (word).
REQ-024 Store data SHALL be replicated into all lanes: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word wdata.
REQ-025 Load data SHALL select lane by addr[1:0] (byte) or addr[1] (half), then sign- or zero-extend to 32 bits per req_unsigned; word passes unchanged.
REQ-026 mem_ack outside ACCESS SHALL be ignored.

Reset
REQ-027 On rst high, asynchronously: state = IDLE, timeout counter = 0, all captured registers = 0.
REQ-028 During and after reset: req_ready = 1, resp_valid = 0, resp_err = 0, resp_rdata = 0, mem_req = 0, mem_we = 0, mem_addr = 0, mem_be = 0, mem_wdata = 0.
REQ-029 Reset asserted mid-ACCESS SHALL drop mem_req immediately and produce no response.

Configuration
REQ-030 Macro LSU_MISALIGN_TRAP_EN SHALL control alignment checking.
REQ-031 Defined: half with addr[0] = 1 or word with addr[1:0] != 00 SHALL skip ACCESS (no mem_req) and respond via RESP with resp_err = 1.
REQ-032 Undefined: no check; low address bits ignored (half uses addr[1] only, word ignores addr[1:0]); never flags misalignment.

Verification
REQ-033 Load byte, addr 0x103, unsigned = 0, mem_rdata 0x80FF_1234 acked in first ACCESS cycle -> mem_addr 0x100, mem_be 1000, resp_rdata 0xFFFF_FF80, resp_err 0, resp_valid 2 cycles after acceptance.
REQ-034 Load half, addr 0x102, unsigned = 1, mem_rdata 0x9ABC_0000 -> mem_be 1100, resp_rdata 0x0000_9ABC.
REQ-035 Store byte, addr 0x201, wdata 0x0000_00A5 -> mem_we 1, mem_be 0010, mem_wdata 0xA5A5_A5A5, resp_rdata 0.
REQ-036 TIMEOUT_CYCLES = 4, mem_ack never asserted -> mem_req high 4 cycles, then resp_valid with resp_err 1.
REQ-037 With LSU_MISALIGN_TRAP_EN, word load at 0x102 -> mem_req never asserted, resp_err 1; without it -> mem_addr 0x100, mem_be 1111, resp_err 0.
REQ-038 rst pulsed during ACCESS with mem_ack delayed -> mem_req low same cycle, no resp_valid, req_ready 1 after release.
